// File: rtl/sha256_msg_schedule_if.sv
// Block-in / word-out handshake bundle for the SHA-256 message schedule.
// master drives blocks and consumes words; slave is the schedule engine.
interface sha256_msg_schedule_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_out, w_idx, w_last
  );

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_out, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 through a
// 16-word sliding window, one word per accepted handshake.
module sha256_msg_schedule (
  input  logic                        clk,
  input  logic                        rst,
  sha256_msg_schedule_if.slave        sched
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [31:0]         win_q [16];
  logic [31:0]         win_d [16];
  logic [31:0]         shift_in [16];
  logic [15:0][31:0]   blk_words;
  logic [5:0]          idx_q, idx_d;
  logic [31:0]         new_word;
  logic                accept;
  logic                xfer;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign accept   = (state_q == IDLE) && sched.blk_valid;
  assign xfer     = (state_q == RUN) && sched.w_ready;
  assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // M0 sits in the top word of blk_data and lands in window entry 0
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_blk_word
      assign blk_words[gi] = sched.blk_data[511 - 32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sched.blk_valid) state_d = RUN;
      RUN:     if (sched.w_ready && idx_q == 6'd63) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sched.blk_ready = (state_q == IDLE);
    sched.w_valid   = (state_q == RUN);
    sched.w_last    = (state_q == RUN) && (idx_q == 6'd63);
  end

  assign sched.w_out = win_q[0];
  assign sched.w_idx = idx_q;

  always_comb begin
    for (int i = 0; i < 15; i++) shift_in[i] = win_q[i+1];
    shift_in[15] = new_word;
  end

  always_comb begin
    idx_d = idx_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (accept) begin
      idx_d = 6'd0;
      for (int i = 0; i < 16; i++) win_d[i] = blk_words[i];
    end else if (xfer) begin
      idx_d = idx_q + 6'd1;
      for (int i = 0; i < 16; i++) win_d[i] = shift_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 6'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      idx_q <= idx_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: abc vector, stalls, mid-run reset,
// back-to-back blocks and random blocks against a recurrence-based model.
module tb_sha256_msg_schedule;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [511:0] abc_blk;
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule dut (
    .clk   (clk),
    .rst   (rst),
    .sched (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic gen_exp(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] b);
    bus.blk_valid = 1'b1;
    bus.blk_data  = b;
    tick();
    bus.blk_valid = 1'b0;
    bus.blk_data  = ~b;
  endtask

  // Consume nwords words; rnd adds random ready plus 3-cycle stalls at t=15,16
  task automatic drain(input bit rnd, input int nwords, input string tag);
    int t     = 0;
    int cyc   = 0;
    int stall = 0;
    while (t < nwords && cyc < 1000) begin
      if (!rnd)                                  bus.w_ready = 1'b1;
      else if ((t == 15 || t == 16) && stall < 3) begin bus.w_ready = 1'b0; stall++; end
      else                                       bus.w_ready = 1'($urandom_range(0, 1));
      check($sformatf("%s valid t=%0d", tag, t), {31'd0, bus.w_valid}, 32'd1);
      check($sformatf("%s w_out t=%0d", tag, t), bus.w_out, exp_w[t]);
      check($sformatf("%s w_idx t=%0d", tag, t), {26'd0, bus.w_idx}, t);
      check($sformatf("%s w_last t=%0d", tag, t), {31'd0, bus.w_last}, {31'd0, t == 63});
      got_w[t] = bus.w_out;
      tick();
      cyc++;
      if (bus.w_ready) begin
        t++;
        stall = 0;
      end
    end
    check($sformatf("%s transfers", tag), t, nwords);
    bus.w_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s blk_ready", tag), {31'd0, bus.blk_ready}, 32'd1);
    check($sformatf("%s w_valid", tag), {31'd0, bus.w_valid}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b1;
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};

    // reset state
    tick();
    tick();
    rst = 1'b0;
    bus.w_ready = 1'b0;
    check_idle("reset");
    check("reset w_out", bus.w_out, 32'd0);
    check("reset w_idx", {26'd0, bus.w_idx}, 32'd0);
    check("reset w_last", {31'd0, bus.w_last}, 32'd0);
    $display("reset released");

    // abc block, ready tied high
    gen_exp(abc_blk);
    send_block(abc_blk);
    drain(1'b0, 64, "abc");
    check("abc W0", got_w[0], 32'h61626380);
    check("abc W15", got_w[15], 32'h00000018);
    check("abc W16", got_w[16], 32'h61626380);
    check("abc W17", got_w[17], 32'h000F0000);
    check("abc W18", got_w[18], 32'h7DA86405);
    check("abc W19", got_w[19], 32'h600003C6);
    check_idle("abc end");
    $display("block abc streamed with w_ready high");

    // abc block with stalls
    send_block(abc_blk);
    drain(1'b1, 64, "abc_stall");
    check_idle("abc_stall end");
    $display("block abc streamed with stalls");

    // reset mid-run at t=40, then fresh block from t=0
    blk_a = rand_blk();
    gen_exp(blk_a);
    send_block(blk_a);
    drain(1'b0, 40, "abort");
    rst = 1'b1;
    bus.w_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.w_ready = 1'b0;
    check_idle("abort rst");
    check("abort w_idx", {26'd0, bus.w_idx}, 32'd0);
    check("abort w_out", bus.w_out, 32'd0);
    blk_b = rand_blk();
    gen_exp(blk_b);
    send_block(blk_b);
    drain(1'b0, 64, "after_abort");
    $display("block aborted at t=40, next block streamed");

    // blk_valid held high across two blocks; blk_data changes during RUN
    blk_a = rand_blk();
    blk_b = rand_blk();
    bus.blk_valid = 1'b1;
    bus.blk_data  = blk_a;
    tick();
    bus.blk_data  = blk_b;
    gen_exp(blk_a);
    drain(1'b0, 64, "b2b_a");
    check_idle("b2b bubble");
    tick();
    bus.blk_valid = 1'b0;
    bus.blk_data  = rand_blk();
    gen_exp(blk_b);
    drain(1'b0, 64, "b2b_b");
    check_idle("b2b end");
    $display("back-to-back blocks streamed with one-cycle bubble");

    // reset wins over simultaneous blk_valid
    rst = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = blk_a;
    tick();
    rst = 1'b0;
    bus.blk_valid = 1'b0;
    check_idle("rst+valid");
    tick();
    check_idle("rst+valid next");
    $display("reset with blk_valid: no accept");

    // random blocks
    for (int k = 0; k < 20; k++) begin
      blk_a = rand_blk();
      gen_exp(blk_a);
      send_block(blk_a);
      drain(1'b0, 64, $sformatf("rnd%0d", k));
      $display("random block %0d streamed, W63=%h", k, got_w[63]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
